// File: rtl/sdrc_mport_pkg.sv
// Shared types for the multi-port SDRAM front end: port-id width and arbiter FSM states.
package sdrc_mport_pkg;
   localparam int MAX_PORTS = 8;
   localparam int PID_W     = $clog2(MAX_PORTS);

   typedef logic [PID_W-1:0] port_id_t;
   typedef enum logic {IDLE, ISSUE} arb_state_e;
endpackage

// File: rtl/sdrc_tag_fifo.sv
// Synchronous in-order FIFO of port ids, one per outstanding burst direction.
module sdrc_tag_fifo
   import sdrc_mport_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  port_id_t                   din_i,
   output port_id_t                   dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);

   port_id_t          mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/sdrc_mport_arb.sv
// Round-robin N-port request arbiter for sdrc_core with in-order write/read data routing.
// Define SDRC_MPORT_PRIO_EN to give port 0 strict priority over rotating ports 1..N-1.
module sdrc_mport_arb
   import sdrc_mport_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int APP_AW    = 26,
   parameter int dw        = 32,
   parameter int bl        = 9,
   parameter int TAG_DEPTH = 4
) (
   input  logic                          sdram_clk,
   input  logic                          sdram_reset,
   input  logic [NUM_PORTS-1:0]          p_req,
   input  logic [NUM_PORTS*APP_AW-1:0]   p_req_addr,
   input  logic [NUM_PORTS*bl-1:0]       p_req_len,
   input  logic [NUM_PORTS-1:0]          p_req_wr_n,
   output logic [NUM_PORTS-1:0]          p_req_ack,
   input  logic [NUM_PORTS*dw-1:0]       p_wr_data,
   input  logic [NUM_PORTS*dw/8-1:0]     p_wr_en_n,
   output logic [NUM_PORTS-1:0]          p_wr_next,
   output logic [NUM_PORTS-1:0]          p_rd_valid,
   output logic [NUM_PORTS-1:0]          p_last_rd,
   output logic [dw-1:0]                 p_rd_data,
   output logic                          app_req,
   output logic [APP_AW-1:0]             app_req_addr,
   output logic [bl-1:0]                 app_req_len,
   output logic                          app_req_wr_n,
   input  logic                          app_req_ack,
   output logic [dw-1:0]                 app_wr_data,
   output logic [dw/8-1:0]               app_wr_en_n,
   input  logic                          app_wr_next_req,
   input  logic                          app_rd_valid,
   input  logic                          app_last_rd,
   input  logic                          app_last_wr,
   input  logic [dw-1:0]                 app_rd_data
);
   localparam int BW = dw/8;
   localparam int CW = $clog2(TAG_DEPTH)+1;

   arb_state_e           state_q;
   port_id_t             id_q, ptr_q, ptr_d, gnt_id, wr_head, rd_head;
   logic                 gnt_vld, acc;
   logic [NUM_PORTS-1:0] elig;
   logic [APP_AW-1:0]    sel_addr;
   logic [bl-1:0]        sel_len;
   logic                 sel_wr_n;
   logic                 wr_full, wr_empty, rd_full, rd_empty;
   logic [CW-1:0]        wr_cnt, rd_cnt;

   // A port is eligible only if its destination tag FIFO can take another burst.
   always_comb begin
      int base, idx;
      elig    = '0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      base    = 0;
      idx     = 0;
      for (int i = 0; i < NUM_PORTS; i++)
         elig[i] = p_req[i] & (p_req_wr_n[i] ? ~rd_full : ~wr_full);
`ifdef SDRC_MPORT_PRIO_EN
      if (elig[0]) begin
         gnt_vld = 1'b1;
      end else begin
         base = (ptr_q == '0) ? 0 : int'(ptr_q) - 1;
         for (int k = 0; k < NUM_PORTS-1; k++) begin
            idx = 1 + ((base + k) % (NUM_PORTS-1));
            if (!gnt_vld && elig[idx]) begin
               gnt_vld = 1'b1;
               gnt_id  = port_id_t'(idx);
            end
         end
      end
`else
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = (int'(ptr_q) + k) % NUM_PORTS;
         if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = port_id_t'(idx);
         end
      end
`endif
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      sel_wr_n = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_id == port_id_t'(i)) begin
            sel_addr = p_req_addr[i*APP_AW +: APP_AW];
            sel_len  = p_req_len[i*bl +: bl];
            sel_wr_n = p_req_wr_n[i];
         end
      end
   end

   always_comb begin
`ifdef SDRC_MPORT_PRIO_EN
      if (id_q == '0)                          ptr_d = ptr_q;
      else if (int'(id_q) == NUM_PORTS-1)      ptr_d = port_id_t'(1);
      else                                     ptr_d = id_q + port_id_t'(1);
`else
      if (int'(id_q) == NUM_PORTS-1)           ptr_d = '0;
      else                                     ptr_d = id_q + port_id_t'(1);
`endif
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_reset) begin
         state_q      <= IDLE;
         app_req      <= 1'b0;
         app_req_addr <= '0;
         app_req_len  <= '0;
         app_req_wr_n <= 1'b1;
         id_q         <= '0;
         ptr_q        <= '0;
      end else begin
         case (state_q)
            IDLE: if (gnt_vld) begin
               state_q      <= ISSUE;
               app_req      <= 1'b1;
               app_req_addr <= sel_addr;
               app_req_len  <= sel_len;
               app_req_wr_n <= sel_wr_n;
               id_q         <= gnt_id;
            end
            ISSUE: if (app_req_ack) begin
               state_q <= IDLE;
               app_req <= 1'b0;
               ptr_q   <= ptr_d;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Acceptance is suppressed during reset so a flushed request is never acked.
   assign acc = (state_q == ISSUE) & app_req_ack & ~sdram_reset;

   always_comb begin
      p_req_ack = '0;
      if (acc) p_req_ack[id_q] = 1'b1;
   end

   sdrc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_wr_tags (
      .clk     (sdram_clk),
      .rst     (sdram_reset),
      .push_i  (acc & ~app_req_wr_n),
      .pop_i   (app_wr_next_req & app_last_wr),
      .din_i   (id_q),
      .dout_o  (wr_head),
      .full_o  (wr_full),
      .empty_o (wr_empty),
      .count_o (wr_cnt)
   );

   sdrc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_rd_tags (
      .clk     (sdram_clk),
      .rst     (sdram_reset),
      .push_i  (acc & app_req_wr_n),
      .pop_i   (app_rd_valid & app_last_rd),
      .din_i   (id_q),
      .dout_o  (rd_head),
      .full_o  (rd_full),
      .empty_o (rd_empty),
      .count_o (rd_cnt)
   );

   always_comb begin
      app_wr_data = '0;
      app_wr_en_n = '1;
      p_wr_next   = '0;
      p_rd_valid  = '0;
      p_last_rd   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (wr_head == port_id_t'(i)) begin
            app_wr_data  = p_wr_data[i*dw +: dw];
            app_wr_en_n  = p_wr_en_n[i*BW +: BW];
            p_wr_next[i] = app_wr_next_req & ~wr_empty;
         end
         if (rd_head == port_id_t'(i)) begin
            p_rd_valid[i] = app_rd_valid & ~rd_empty;
            p_last_rd[i]  = app_last_rd & app_rd_valid & ~rd_empty;
         end
      end
   end

   assign p_rd_data = app_rd_data;

endmodule
